// File: rtl/uart_cmd_rx_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_cmd_rx_if
// Description : Bundle carrying the serial input and the decoded command
//               outputs of the PC-link receive path.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_rx_if;
   logic       rx;
   logic [7:0] rx_byte;
   logic       rx_byte_vld;
   logic       frame_err;
   logic       meas_req;
   logic [9:0] period;
   logic       period_vld;
   logic       cmd_err;

   // Receiver side: consumes the line, produces the decoded controls.
   modport slave (
      input  rx,
      output rx_byte, rx_byte_vld, frame_err, meas_req, period, period_vld, cmd_err
   );

   // Host/observer side: drives the line, consumes the decoded controls.
   modport master (
      output rx,
      input  rx_byte, rx_byte_vld, frame_err, meas_req, period, period_vld, cmd_err
   );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_cmd_rx
// Description : 8N1 UART receiver plus ASCII command-line decoder. "M<CR>"
//               requests a measurement, "P<1..3 digits><CR>" loads the
//               sample period (100 ms units). LF is ignored everywhere.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_rx #(
   parameter int         CLK_FREQ       = 50_000_000,
   parameter int         BAUD           = 115200,
   parameter logic [9:0] PERIOD_DEFAULT = 10'd10
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   uart_cmd_rx_if.slave bus
);

   localparam int BIT_DIV  = CLK_FREQ / BAUD;
   localparam int HALF_DIV = BIT_DIV / 2;
   localparam int CNT_W    = $clog2(BIT_DIV);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV - 1);

   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;

   typedef enum logic [2:0] {
      R_IDLE   = 3'd0,
      R_START  = 3'd1,
      R_DATA   = 3'd2,
      R_STOP   = 3'd3,
      R_WAITHI = 3'd4
   } rx_state_t;

   typedef enum logic [1:0] {
      P_IDLE = 2'd0,
      P_M    = 2'd1,
      P_DIG  = 2'd2,
      P_DISC = 2'd3
   } p_state_t;

   // ------------------------------------------------------------------------
   // Line synchronizer and falling-edge detect
   // ------------------------------------------------------------------------
   logic r_sync1, r_sync2, r_sync3;
   logic w_fall;

   // Two flops for metastability, a third to see the previous synchronized level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_sync3 <= 1'b1;
      end else begin
         r_sync1 <= bus.rx;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_fall = r_sync3 & ~r_sync2;

   // ------------------------------------------------------------------------
   // Receiver FSM
   // ------------------------------------------------------------------------
   rx_state_t        r_rx_state, w_rx_state_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;
   logic [2:0]       r_bit_idx, w_bit_idx_nx;
   logic [7:0]       r_shift, w_shift_nx;
   logic [7:0]       r_rx_byte, w_rx_byte_nx;
   logic             r_rx_byte_vld, w_rx_byte_vld_nx;
   logic             r_frame_err, w_frame_err_nx;

   // Receiver state, bit timer, shift register and registered byte outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_state    <= R_IDLE;
         r_cnt         <= '0;
         r_bit_idx     <= '0;
         r_shift       <= '0;
         r_rx_byte     <= '0;
         r_rx_byte_vld <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_rx_state    <= w_rx_state_nx;
         r_cnt         <= w_cnt_nx;
         r_bit_idx     <= w_bit_idx_nx;
         r_shift       <= w_shift_nx;
         r_rx_byte     <= w_rx_byte_nx;
         r_rx_byte_vld <= w_rx_byte_vld_nx;
         r_frame_err   <= w_frame_err_nx;
      end
   end

   // Bit timing: start bit checked at half period, then one sample per bit period (mid-bit).
   always_comb begin
      w_rx_state_nx    = r_rx_state;
      w_cnt_nx         = r_cnt + 1'b1;
      w_bit_idx_nx     = r_bit_idx;
      w_shift_nx       = r_shift;
      w_rx_byte_nx     = r_rx_byte;
      w_rx_byte_vld_nx = 1'b0;
      w_frame_err_nx   = 1'b0;
      case (r_rx_state)
         R_IDLE: begin
            w_cnt_nx = '0;
            if (w_fall) begin
               w_rx_state_nx = R_START;
            end
         end
         R_START: begin
            if (r_cnt == CNT_HALF) begin
               w_cnt_nx = '0;
               if (r_sync2) begin
                  // Line went back high before mid start bit: a glitch, not a frame.
                  w_rx_state_nx = R_IDLE;
               end else begin
                  w_bit_idx_nx  = '0;
                  w_rx_state_nx = R_DATA;
               end
            end
         end
         R_DATA: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nx     = '0;
               w_shift_nx   = {r_sync2, r_shift[7:1]};
               w_bit_idx_nx = r_bit_idx + 3'd1;
               if (r_bit_idx == 3'd7) begin
                  w_rx_state_nx = R_STOP;
               end
            end
         end
         R_STOP: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nx = '0;
               if (r_sync2) begin
                  // Leaving at mid stop bit lets a back-to-back start edge be caught.
                  w_rx_byte_nx     = r_shift;
                  w_rx_byte_vld_nx = 1'b1;
                  w_rx_state_nx    = R_IDLE;
               end else begin
                  w_frame_err_nx = 1'b1;
                  w_rx_state_nx  = R_WAITHI;
               end
            end
         end
         R_WAITHI: begin
            w_cnt_nx = '0;
            if (r_sync2) begin
               w_rx_state_nx = R_IDLE;
            end
         end
         default: begin
            w_cnt_nx      = '0;
            w_rx_state_nx = R_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Command parser FSM
   // ------------------------------------------------------------------------
   p_state_t   r_p_state, w_p_state_nx;
   logic [9:0] r_acc, w_acc_nx;
   logic [1:0] r_dcnt, w_dcnt_nx;
   logic [9:0] r_period, w_period_nx;
   logic       r_period_vld, w_period_vld_nx;
   logic       r_meas_req, w_meas_req_nx;
   logic       r_cmd_err, w_cmd_err_nx;

   logic       w_is_lf, w_is_cr, w_is_m, w_is_p, w_is_digit;
   logic [9:0] w_acc_mac;

   assign w_is_lf    = (r_rx_byte == CH_LF);
   assign w_is_cr    = (r_rx_byte == CH_CR);
   assign w_is_m     = (r_rx_byte == 8'h4D) || (r_rx_byte == 8'h6D);
   assign w_is_p     = (r_rx_byte == 8'h50) || (r_rx_byte == 8'h70);
   assign w_is_digit = (r_rx_byte >= 8'h30) && (r_rx_byte <= 8'h39);

   // acc*10 + digit with shifts; acc is at most 99 here, so the result stays below 1000.
   assign w_acc_mac  = {r_acc[6:0], 3'b000} + {r_acc[8:0], 1'b0} + {6'd0, r_rx_byte[3:0]};

   // Parser state, digit accumulator, period register and its pulse outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p_state    <= P_IDLE;
         r_acc        <= '0;
         r_dcnt       <= '0;
         r_period     <= PERIOD_DEFAULT;
         r_period_vld <= 1'b0;
         r_meas_req   <= 1'b0;
         r_cmd_err    <= 1'b0;
      end else begin
         r_p_state    <= w_p_state_nx;
         r_acc        <= w_acc_nx;
         r_dcnt       <= w_dcnt_nx;
         r_period     <= w_period_nx;
         r_period_vld <= w_period_vld_nx;
         r_meas_req   <= w_meas_req_nx;
         r_cmd_err    <= w_cmd_err_nx;
      end
   end

   // Line decoding; an error sends the line to discard so it reports only once.
   always_comb begin
      w_p_state_nx    = r_p_state;
      w_acc_nx        = r_acc;
      w_dcnt_nx       = r_dcnt;
      w_period_nx     = r_period;
      w_period_vld_nx = 1'b0;
      w_meas_req_nx   = 1'b0;
      w_cmd_err_nx    = 1'b0;
      if (r_frame_err) begin
         if (r_p_state != P_DISC) begin
            w_cmd_err_nx = 1'b1;
            w_p_state_nx = P_DISC;
         end
      end else if (r_rx_byte_vld && !w_is_lf) begin
         case (r_p_state)
            P_IDLE: begin
               if (w_is_m) begin
                  w_p_state_nx = P_M;
               end else if (w_is_p) begin
                  w_acc_nx     = '0;
                  w_dcnt_nx    = '0;
                  w_p_state_nx = P_DIG;
               end else if (!w_is_cr) begin
                  w_cmd_err_nx = 1'b1;
                  w_p_state_nx = P_DISC;
               end
            end
            P_M: begin
               if (w_is_cr) begin
                  w_meas_req_nx = 1'b1;
                  w_p_state_nx  = P_IDLE;
               end else begin
                  w_cmd_err_nx = 1'b1;
                  w_p_state_nx = P_DISC;
               end
            end
            P_DIG: begin
               if (w_is_digit) begin
                  if (r_dcnt != 2'd3) begin
                     w_acc_nx  = w_acc_mac;
                     w_dcnt_nx = r_dcnt + 2'd1;
                  end else begin
                     w_cmd_err_nx = 1'b1;
                     w_p_state_nx = P_DISC;
                  end
               end else if (w_is_cr) begin
                  if ((r_dcnt != 2'd0) && (r_acc != 10'd0)) begin
                     w_period_nx     = r_acc;
                     w_period_vld_nx = 1'b1;
                  end else begin
                     w_cmd_err_nx = 1'b1;
                  end
                  w_p_state_nx = P_IDLE;
               end else begin
                  w_cmd_err_nx = 1'b1;
                  w_p_state_nx = P_DISC;
               end
            end
            P_DISC: begin
               if (w_is_cr) begin
                  w_p_state_nx = P_IDLE;
               end
            end
            default: begin
               w_p_state_nx = P_IDLE;
            end
         endcase
      end
   end

   assign bus.rx_byte     = r_rx_byte;
   assign bus.rx_byte_vld = r_rx_byte_vld;
   assign bus.frame_err   = r_frame_err;
   assign bus.meas_req    = r_meas_req;
   assign bus.period      = r_period;
   assign bus.period_vld  = r_period_vld;
   assign bus.cmd_err     = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_cmd_rx
// Description : Self-checking bench for uart_cmd_rx; directed command lines
//               followed by random lines, checked against a line-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_rx;

   localparam int CLK_FREQ = 3_200_000;
   localparam int BAUD     = 100_000;
   localparam int BITP     = CLK_FREQ / BAUD;   // 32 clocks per bit

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   uart_cmd_rx_if bus ();

   uart_cmd_rx #(
      .CLK_FREQ      (CLK_FREQ),
      .BAUD          (BAUD),
      .PERIOD_DEFAULT(10'd10)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // ------------------------------------------------------------------------
   // Output monitor: counts pulses and records received bytes
   // ------------------------------------------------------------------------
   int         cyc = 0, n_vld = 0, n_ferr = 0, n_meas = 0, n_pvld = 0, n_cerr = 0;
   int         n_wide = 0, n_orphan = 0, n_multi = 0;
   int         last_vld_cyc = 0, last_meas_cyc = 0;
   logic [7:0] got_q[$];
   logic [4:0] prev_p = 5'd0;
   logic [4:0] mon_p;

   assign mon_p = {bus.rx_byte_vld, bus.frame_err, bus.meas_req, bus.period_vld, bus.cmd_err};

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (mon_p[4]) begin
         got_q.push_back(bus.rx_byte);
         n_vld        <= n_vld + 1;
         last_vld_cyc <= cyc;
      end
      if (mon_p[3]) n_ferr <= n_ferr + 1;
      if (mon_p[2]) begin
         n_meas        <= n_meas + 1;
         last_meas_cyc <= cyc;
      end
      if (mon_p[1]) n_pvld <= n_pvld + 1;
      if (mon_p[0]) n_cerr <= n_cerr + 1;
      if (|(mon_p & prev_p)) n_wide <= n_wide + 1;
      if ((|mon_p[2:0]) && !(|prev_p[4:3])) n_orphan <= n_orphan + 1;
      if ($countones(mon_p[2:0]) > 1) n_multi <= n_multi + 1;
      prev_p <= mon_p;
   end

   // ------------------------------------------------------------------------
   // Line-level reference model
   // ------------------------------------------------------------------------
   logic [7:0] line_q[$];
   logic [7:0] exp_q[$];
   bit         line_bad   = 1'b0;
   int         exp_meas   = 0, exp_pvld = 0, exp_cerr = 0, exp_ferr = 0;
   int         exp_period = 10;
   int         got_rd     = 0, exp_rd = 0;

   // A complete line is judged as a whole: any invalid line yields exactly one error.
   task automatic model_eol();
      int  n;
      int  val;
      bit  ok;
      n = line_q.size();
      if (line_bad) begin
         exp_cerr++;
      end else if (n == 0) begin
         // empty line
      end else if (n == 1 && (line_q[0] == 8'h4D || line_q[0] == 8'h6D)) begin
         exp_meas++;
      end else if ((line_q[0] == 8'h50 || line_q[0] == 8'h70) && n >= 2 && n <= 4) begin
         ok  = 1'b1;
         val = 0;
         for (int i = 1; i < n; i++) begin
            if (line_q[i] < 8'h30 || line_q[i] > 8'h39) ok = 1'b0;
            else val = val * 10 + (int'(line_q[i]) - 48);
         end
         if (ok && val != 0) begin
            exp_period = val;
            exp_pvld++;
         end else begin
            exp_cerr++;
         end
      end else begin
         exp_cerr++;
      end
      line_q.delete();
      line_bad = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      exp_q.push_back(b);
      if (b == 8'h0D) model_eol();
      else if (b != 8'h0A) line_q.push_back(b);
   endtask

   task automatic model_reset();
      line_q.delete();
      line_bad   = 1'b0;
      exp_period = 10;
   endtask

   // ------------------------------------------------------------------------
   // Stimulus and check helpers
   // ------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      bus.rx = 1'b0;
      repeat (BITP) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         repeat (BITP) @(posedge clk);
      end
      bus.rx = stop_ok;
      repeat (BITP) @(posedge clk);
      if (!stop_ok) begin
         bus.rx = 1'b1;
         repeat (BITP) @(posedge clk);
      end
      bus.rx = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b1);
      model_byte(b);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic send_bad(input logic [7:0] b);
      send_frame(b, 1'b0);
      exp_ferr++;
      line_bad = 1'b1;
   endtask

   task automatic check_state(input string tag);
      repeat (4) @(posedge clk);
      #1;
      check({tag, ".meas"},   32'(n_meas), 32'(exp_meas));
      check({tag, ".pvld"},   32'(n_pvld), 32'(exp_pvld));
      check({tag, ".cerr"},   32'(n_cerr), 32'(exp_cerr));
      check({tag, ".ferr"},   32'(n_ferr), 32'(exp_ferr));
      check({tag, ".period"}, 32'(bus.period), 32'(exp_period));
      check({tag, ".nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (got_rd < got_q.size() && exp_rd < exp_q.size()) begin
         check({tag, ".byte"}, 32'(got_q[got_rd]), 32'(exp_q[exp_rd]));
         got_rd++;
         exp_rd++;
      end
      got_rd = got_q.size();
      exp_rd = exp_q.size();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".rx_byte"}, 32'(bus.rx_byte),     32'd0);
      check({tag, ".vld"},     32'(bus.rx_byte_vld), 32'd0);
      check({tag, ".ferr"},    32'(bus.frame_err),   32'd0);
      check({tag, ".meas"},    32'(bus.meas_req),    32'd0);
      check({tag, ".pvld"},    32'(bus.period_vld),  32'd0);
      check({tag, ".cerr"},    32'(bus.cmd_err),     32'd0);
      check({tag, ".period"},  32'(bus.period),      32'd10);
   endtask

   // Hard stop in case anything stalls.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------------
   // Directed and random sequence
   // ------------------------------------------------------------------------
   initial begin
      int kind;
      int nd;
      bus.rx = 1'b1;
      rst_n  = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (200) @(posedge clk);
      check_state("idle");

      // Measurement command, then timing of meas_req against the CR byte
      send_str("M\r");
      repeat (3) @(posedge clk);
      #1;
      check("m_cmd.latency", 32'(last_meas_cyc - last_vld_cyc), 32'd1);
      send_str("\n");
      check_state("m_cmd");

      // Two period commands back to back
      send_str("P250\r");
      #1;
      check("p250.period", 32'(bus.period), 32'd250);
      send_str("p7\r");
      check_state("p7");

      // Fourth digit reports at the '4', not at CR
      send_str("P123");
      repeat (3) @(posedge clk);
      #1;
      check("p1234.before4", 32'(n_cerr), 32'(exp_cerr));
      send_str("4");
      repeat (3) @(posedge clk);
      #1;
      check("p1234.at4", 32'(n_cerr), 32'(exp_cerr + 1));
      send_str("\r");
      check_state("p1234");
      send_str("M\r");
      check_state("p1234.m");

      send_str("P0\r");  check_state("p0");
      send_str("M\r");   check_state("p0.m");
      send_str("P\r");   check_state("p_empty");
      send_str("M\r");   check_state("p_empty.m");
      send_str("X5\r");  check_state("x5");
      send_str("M\r");   check_state("x5.m");

      // Short low glitch is not a frame
      bus.rx = 1'b0;
      repeat (10) @(posedge clk);
      bus.rx = 1'b1;
      repeat (100) @(posedge clk);
      check_state("glitch");

      // Framing error inside "P12"
      send_str("P1");
      send_bad(8'h32);
      repeat (2) @(posedge clk);
      #1;
      check("ferr.cerr", 32'(n_cerr), 32'(exp_cerr + 1));
      send_str("3\r");
      check_state("ferr.line");
      send_str("P300\r");
      check_state("ferr.p300");

      // Reset in the middle of a frame
      send_str("P5");
      fork
         send_frame(8'h4D, 1'b1);
         begin
            repeat (BITP * 5) @(posedge clk);
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midrst");
         end
      join
      model_reset();
      repeat (5) @(posedge clk);
      rst_n = 1'b1;
      repeat (BITP) @(posedge clk);
      check_state("midrst.idle");
      send_str("M\r");
      check_state("midrst.m");

      // Random command lines
      for (int ln = 0; ln < 12; ln++) begin
         kind = int'($urandom_range(0, 5));
         case (kind)
            0: send_byte(($urandom_range(0, 1) != 0) ? 8'h4D : 8'h6D);
            1: begin
               send_byte(($urandom_range(0, 1) != 0) ? 8'h50 : 8'h70);
               nd = int'($urandom_range(1, 3));
               for (int d = 0; d < nd; d++) send_byte(8'(8'h30 + $urandom_range(0, 9)));
            end
            2: begin
               send_byte(8'h50);
               for (int d = 0; d < 4; d++) send_byte(8'(8'h30 + $urandom_range(0, 9)));
            end
            3: begin
               nd = int'($urandom_range(1, 3));
               for (int d = 0; d < nd; d++) send_byte(8'($urandom_range(32, 126)));
            end
            4: ;
            default: begin
               send_byte(8'h50);
               send_bad(8'($urandom_range(0, 255)));
               send_byte(8'(8'h30 + $urandom_range(0, 9)));
            end
         endcase
         send_byte(8'h0D);
         if ($urandom_range(0, 1) != 0) send_byte(8'h0A);
         check_state($sformatf("rnd%0d", ln));
      end

      // Pulse-shape properties gathered over the whole run
      check("pulse_width", 32'(n_wide),   32'd0);
      check("pulse_cause", 32'(n_orphan), 32'd0);
      check("pulse_multi", 32'(n_multi),  32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
